// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared types and constants for the load/store unit
package lsu_pkg;

   localparam int unsigned BYTE_W = 8;
   localparam int unsigned HALF_W = 16;
   localparam int unsigned WORD_W = 32;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'b00,
      SZ_HALF = 2'b01,
      SZ_WORD = 2'b10,
      SZ_RSVD = 2'b11
   } lsu_size_e;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      CHECK  = 3'd1,
      ACCESS = 3'd2,
      WRITE  = 3'd3,
      RESP   = 3'd4
   } lsu_state_e;

endpackage

// File: rtl/lsu_lane_align.sv
// rtl/lsu_lane_align.sv - little-endian lane extract/extend and lane merge
module lsu_lane_align
   import lsu_pkg::*;
(
   input  logic [WORD_W-1:0] rd_word,
   input  logic [WORD_W-1:0] mg_word,
   input  logic [WORD_W-1:0] wdata,
   input  logic [1:0]        offset,
   input  lsu_size_e         size,
   input  logic              sgn,
   output logic [WORD_W-1:0] rdata,
   output logic [WORD_W-1:0] merged
);

   logic [BYTE_W-1:0] lane_b;
   logic [HALF_W-1:0] lane_h;

   // Pick the addressed byte/halfword and extend it to a full word
   always_comb begin
      lane_b = rd_word[7:0];
      case (offset)
         2'd0:    lane_b = rd_word[7:0];
         2'd1:    lane_b = rd_word[15:8];
         2'd2:    lane_b = rd_word[23:16];
         default: lane_b = rd_word[31:24];
      endcase
      lane_h = offset[1] ? rd_word[31:16] : rd_word[15:0];
      case (size)
         SZ_BYTE: rdata = sgn ? {{(WORD_W-BYTE_W){lane_b[BYTE_W-1]}}, lane_b}
                              : {{(WORD_W-BYTE_W){1'b0}}, lane_b};
         SZ_HALF: rdata = sgn ? {{(WORD_W-HALF_W){lane_h[HALF_W-1]}}, lane_h}
                              : {{(WORD_W-HALF_W){1'b0}}, lane_h};
         default: rdata = rd_word;
      endcase
   end

   // Replace the target lane(s) of the buffered word with the store data
   always_comb begin
      merged = mg_word;
      case (size)
         SZ_BYTE: begin
            case (offset)
               2'd0:    merged[7:0]   = wdata[7:0];
               2'd1:    merged[15:8]  = wdata[7:0];
               2'd2:    merged[23:16] = wdata[7:0];
               default: merged[31:24] = wdata[7:0];
            endcase
         end
         SZ_HALF: begin
            if (offset[1]) merged[31:16] = wdata[15:0];
            else           merged[15:0]  = wdata[15:0];
         end
         default: merged = wdata;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - data-memory initiator FSM; LSU_PERF_CNT_EN adds load/store counters
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int unsigned MEM_LIMIT = 6500
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic        req_signed,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic [31:0] address,
   output logic [31:0] write_data,
   output logic        mem_read,
   output logic        mem_write,
   input  logic [31:0] read_data
`ifdef LSU_PERF_CNT_EN
   ,
   output logic [31:0] load_count,
   output logic [31:0] store_count
`endif
);

   lsu_state_e  state_q, state_d;
   logic        we_q;
   lsu_size_e   size_q;
   logic        sgn_q;
   logic [1:0]  off_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [31:0] buf_q;
   logic [31:0] rdata_q;
   logic        err_q;
   logic        chk_err;
   logic [31:0] ext_rdata;
   logic [31:0] merged;

   lsu_lane_align u_align (
      .rd_word (read_data),
      .mg_word (buf_q),
      .wdata   (wdata_q),
      .offset  (off_q),
      .size    (size_q),
      .sgn     (sgn_q),
      .rdata   (ext_rdata),
      .merged  (merged)
   );

   // Misalignment, reserved size, or aligned address beyond the memory
   always_comb begin
      chk_err = (size_q == SZ_RSVD)
             || (size_q == SZ_HALF && off_q[0])
             || (size_q == SZ_WORD && off_q != 2'b00)
             || (addr_q > 32'(MEM_LIMIT));
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (req_valid) state_d = CHECK;
         CHECK:   state_d = chk_err ? RESP : ACCESS;
         ACCESS:  state_d = (we_q && size_q != SZ_WORD) ? WRITE : RESP;
         WRITE:   state_d = RESP;
         RESP:    if (resp_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Outputs decoded from state; memory enables each last a single cycle
   always_comb begin
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      write_data = 32'd0;
      case (state_q)
         IDLE:   req_ready = 1'b1;
         ACCESS: begin
            if (we_q && size_q == SZ_WORD) begin
               mem_write  = 1'b1;
               write_data = wdata_q;
            end else begin
               mem_read = 1'b1;
            end
         end
         WRITE: begin
            mem_write  = 1'b1;
            write_data = merged;
         end
         RESP:    resp_valid = 1'b1;
         default: ;
      endcase
   end

   assign address    = addr_q;
   assign resp_rdata = rdata_q;
   assign resp_err   = err_q;

   // Request latch, error flag, load result and read-modify-write buffer
   always_ff @(posedge clk) begin
      if (rst) begin
         we_q    <= 1'b0;
         size_q  <= SZ_BYTE;
         sgn_q   <= 1'b0;
         off_q   <= 2'b00;
         addr_q  <= 32'd0;
         wdata_q <= 32'd0;
         buf_q   <= 32'd0;
         rdata_q <= 32'd0;
         err_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (req_valid) begin
                  we_q    <= req_we;
                  size_q  <= lsu_size_e'(req_size);
                  sgn_q   <= req_signed;
                  off_q   <= req_addr[1:0];
                  addr_q  <= {req_addr[31:2], 2'b00};
                  wdata_q <= req_wdata;
                  rdata_q <= 32'd0;
                  err_q   <= 1'b0;
               end
            end
            CHECK:  if (chk_err) err_q <= 1'b1;
            ACCESS: begin
               if (!we_q) rdata_q <= ext_rdata;
               else       buf_q   <= read_data;
            end
            default: ;
         endcase
      end
   end

`ifdef LSU_PERF_CNT_EN
   // Count completed non-error accesses at the response handshake
   always_ff @(posedge clk) begin
      if (rst) begin
         load_count  <= 32'd0;
         store_count <= 32'd0;
      end else if (state_q == RESP && resp_ready && !err_q) begin
         if (we_q) store_count <= store_count + 32'd1;
         else      load_count  <= load_count + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - scoreboard bench for load_store_unit
module tb_load_store_unit;
   import lsu_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [1:0]  req_size;
   logic        req_signed;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic [31:0] address;
   logic [31:0] write_data;
   logic        mem_read;
   logic        mem_write;
   logic [31:0] read_data;
`ifdef LSU_PERF_CNT_EN
   logic [31:0] load_count;
   logic [31:0] store_count;
`endif

   always #5 clk = ~clk;

   load_store_unit #(.MEM_LIMIT(6500)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_size   (req_size),
      .req_signed (req_signed),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_rdata (resp_rdata),
      .resp_err   (resp_err),
      .address    (address),
      .write_data (write_data),
      .mem_read   (mem_read),
      .mem_write  (mem_write),
      .read_data  (read_data)
`ifdef LSU_PERF_CNT_EN
      ,
      .load_count  (load_count),
      .store_count (store_count)
`endif
   );

   // word memory: combinational read, clocked write
   logic [31:0] mem [0:2047];
   assign read_data = mem[address[12:2]];
   always @(posedge clk) if (mem_write) mem[address[12:2]] <= write_data;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          lat;
      int          nrd;
      int          nwr;
      int          acc;
   } exp_t;

   exp_t        sbq[$];
   int          errors = 0;
   int          checks = 0;
   int          cyc = 0;
   int          resp_cnt = 0;
   int          nrd = 0;
   int          nwr = 0;
   logic        in_resp = 1'b0;
   logic [31:0] held;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=%h required=%h", name, act, exp);
      end
   endtask

   // monitor: pops the expected response when one appears, checks hold while stalled
   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         nrd = 0;
         nwr = 0;
         in_resp = 1'b0;
      end else begin
         if (mem_read || mem_write) check("rd_wr_exclusive", {31'd0, mem_read & mem_write}, 32'd0);
         nrd += int'(mem_read);
         nwr += int'(mem_write);
         if (resp_valid && !in_resp) begin
            in_resp = 1'b1;
            held = resp_rdata;
            if (sbq.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_resp: actual=%h required=none", resp_rdata);
            end else begin
               e = sbq.pop_front();
               check("resp_rdata", resp_rdata, e.rdata);
               check("resp_err", {31'd0, resp_err}, {31'd0, e.err});
               check("latency", cyc - e.acc, e.lat);
               check("mem_read_pulses", nrd, e.nrd);
               check("mem_write_pulses", nwr, e.nwr);
            end
            nrd = 0;
            nwr = 0;
            resp_cnt++;
         end else if (resp_valid && in_resp) begin
            check("hold_rdata", resp_rdata, held);
            check("hold_req_ready", {31'd0, req_ready}, 32'd0);
         end
         if (!resp_valid) in_resp = 1'b0;
      end
   end

   task automatic issue(input logic we, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] er, input logic ee, input int lat,
                        input int nr, input int nw, input int hold);
      exp_t e;
      int   start;
      @(negedge clk); #1;
      check("req_ready_idle", {31'd0, req_ready}, 32'd1);
      if (hold > 0) resp_ready = 1'b0;
      req_valid = 1'b1; req_we = we; req_size = sz; req_signed = sg;
      req_addr = a; req_wdata = wd;
      e.rdata = er; e.err = ee; e.lat = lat; e.nrd = nr; e.nwr = nw; e.acc = cyc;
      sbq.push_back(e);
      start = resp_cnt;
      @(negedge clk); #1;
      req_valid = 1'b0;
      for (int i = 0; i < 30 && resp_cnt == start; i++) begin
         @(negedge clk); #1;
      end
      if (resp_cnt == start) begin
         checks++;
         errors++;
         $display("FAIL resp_timeout: actual=none required=response addr=%h", a);
         sbq.delete();
      end else if (hold > 0) begin
         repeat (hold) @(negedge clk);
         #1 resp_ready = 1'b1;
         @(negedge clk);
         check("bp_resp_valid_drop", {31'd0, resp_valid}, 32'd0);
         check("bp_req_ready_back", {31'd0, req_ready}, 32'd1);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_req_ready"}, {31'd0, req_ready}, 32'd1);
      check({tag, "_resp_valid"}, {31'd0, resp_valid}, 32'd0);
      check({tag, "_resp_rdata"}, resp_rdata, 32'd0);
      check({tag, "_resp_err"}, {31'd0, resp_err}, 32'd0);
      check({tag, "_mem_read"}, {31'd0, mem_read}, 32'd0);
      check({tag, "_mem_write"}, {31'd0, mem_write}, 32'd0);
      check({tag, "_address"}, address, 32'd0);
      check({tag, "_write_data"}, write_data, 32'd0);
`ifdef LSU_PERF_CNT_EN
      check({tag, "_load_count"}, load_count, 32'd0);
      check({tag, "_store_count"}, store_count, 32'd0);
`endif
   endtask

   initial begin
      int found;
      for (int i = 0; i < 2048; i++) mem[i] = 32'd0;
      mem[1004 >> 2] = 32'h11223344;
      mem[1008 >> 2] = 32'h80F0017F;
      mem[1012 >> 2] = 32'hCAFEBABE;
      mem[6500 >> 2] = 32'h0BADF00D;
      rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
      req_signed = 1'b0; req_addr = 32'd0; req_wdata = 32'd0; resp_ready = 1'b1;
      repeat (2) @(negedge clk);
      check_reset_outputs("reset");
      #1 rst = 1'b0;

      // word store then word load
      issue(1'b1, 2'b10, 1'b0, 32'd1000, 32'hDEADBEEF, 32'h0, 1'b0, 3, 0, 1, 0);
      issue(1'b0, 2'b10, 1'b0, 32'd1000, 32'h0, 32'hDEADBEEF, 1'b0, 3, 1, 0, 0);
      // byte store read-modify-write
      issue(1'b1, 2'b00, 1'b0, 32'd1006, 32'h000000AA, 32'h0, 1'b0, 4, 1, 1, 0);
      check("rmw_byte_mem", mem[1004 >> 2], 32'h11AA3344);
      // sub-word loads
      issue(1'b0, 2'b00, 1'b1, 32'd1010, 32'h0, 32'hFFFFFFF0, 1'b0, 3, 1, 0, 0);
      issue(1'b0, 2'b00, 1'b0, 32'd1010, 32'h0, 32'h000000F0, 1'b0, 3, 1, 0, 0);
      issue(1'b0, 2'b01, 1'b1, 32'd1010, 32'h0, 32'hFFFF80F0, 1'b0, 3, 1, 0, 0);
      issue(1'b0, 2'b01, 1'b1, 32'd1008, 32'h0, 32'h0000017F, 1'b0, 3, 1, 0, 0);
      // errors and the legal top-of-range word
      issue(1'b0, 2'b10, 1'b0, 32'd1002, 32'h0, 32'h0, 1'b1, 2, 0, 0, 0);
      issue(1'b1, 2'b01, 1'b0, 32'd1005, 32'h5555, 32'h0, 1'b1, 2, 0, 0, 0);
      issue(1'b0, 2'b10, 1'b0, 32'd6504, 32'h0, 32'h0, 1'b1, 2, 0, 0, 0);
      issue(1'b0, 2'b11, 1'b0, 32'd1000, 32'h0, 32'h0, 1'b1, 2, 0, 0, 0);
      issue(1'b0, 2'b10, 1'b0, 32'd6500, 32'h0, 32'h0BADF00D, 1'b0, 3, 1, 0, 0);
      // response back-pressure for five cycles
      issue(1'b0, 2'b10, 1'b0, 32'd1000, 32'h0, 32'hDEADBEEF, 1'b0, 3, 1, 0, 5);
`ifdef LSU_PERF_CNT_EN
      @(negedge clk);
      check("load_count", load_count, 32'd7);
      check("store_count", store_count, 32'd2);
`endif

      // reset during the write cycle of a halfword store
      @(negedge clk); #1;
      req_valid = 1'b1; req_we = 1'b1; req_size = 2'b01; req_signed = 1'b0;
      req_addr = 32'd1014; req_wdata = 32'h00001234;
      @(negedge clk); #1;
      req_valid = 1'b0;
      found = 0;
      for (int i = 0; i < 10 && found == 0; i++) begin
         @(negedge clk);
         if (mem_write) found = 1;
      end
      check("reached_write", found, 1);
      #1 rst = 1'b1;
      @(negedge clk);
      check_reset_outputs("midop");
      #1 rst = 1'b0;

      issue(1'b0, 2'b10, 1'b0, 32'd1000, 32'h0, 32'hDEADBEEF, 1'b0, 3, 1, 0, 0);
      repeat (2) @(negedge clk);
      check("scoreboard_drained", sbq.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Initiator side of the data-memory interface. It accepts load and store requests from the pipeline's MEM stage, handles byte and halfword accesses, and drives the word-wide data memory. The memory has a combinational read, a clocked write, and word storage indexed by the aligned byte address.
- Sub-word stores use a read-modify-write sequence.
- Sub-word loads are lane-extracted, then sign- or zero-extended.
- Misaligned and out-of-range requests are reported as errors without touching memory.

Parameters:
- MEM_LIMIT, default 6500: highest legal aligned address. Any aligned address above it is an out-of-range error.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  pipeline request valid
- req_ready  out  1  unit can accept a request
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  access size (lsu_pkg encoding)
- req_signed  in  1  sign-extend sub-word loads
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified
- resp_valid  out  1  response valid
- resp_ready  in  1  pipeline consumes response
- resp_rdata  out  32  load result; 0 for stores and errors
- resp_err  out  1  misaligned or out-of-range request
- address  out  32  memory address (aligned, addr & ~3)
- write_data  out  32  memory write data
- mem_read  out  1  memory read enable
- mem_write  out  1  memory write enable
- read_data  in  32  memory read data, combinational

Behaviour:
- Reset values: state IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, mem_read=0, mem_write=0, address=0, write_data=0.
- Data layout is little-endian. Byte k occupies bits [8k+7:8k]. The halfword at addr[1]=h occupies bits [16h+15:16h].
- State IDLE:
  - req_ready=1.
  - On req_valid, latch we, size, signed, addr, wdata and go to CHECK.
- State CHECK:
  - Error if size=HALF and addr[0]=1, or size=WORD and addr[1:0]!=0, or (addr & ~3) > MEM_LIMIT, or size=2'b11.
  - On error go to RESP with err=1 and rdata=0. No memory enable is asserted.
  - Otherwise go to ACCESS.
- State ACCESS:
  - Load: mem_read=1. Capture the extracted and extended value into resp_rdata, then go to RESP.
  - Store, size=WORD: mem_write=1, write_data=wdata, then go to RESP.
  - Store, sub-word: mem_read=1. Capture read_data into the merge buffer, then go to WRITE.
- State WRITE:
  - mem_write=1.
  - write_data = buffer with the target lane(s) replaced by wdata[7:0] or wdata[15:0].
  - Go to RESP.
- State RESP:
  - resp_valid=1.
  - resp_rdata and resp_err are held stable until resp_ready.
  - On resp_ready, go to IDLE. resp_valid drops the next cycle.
- Latency from acceptance to resp_valid: 3 cycles for loads and word stores, 4 cycles for sub-word stores, 2 cycles for errors.
- Memory enable rules:
  - mem_read and mem_write are never asserted in the same cycle.
  - Each is asserted for exactly one cycle per access.
  - address is stable from CHECK through WRITE.
- Only one request is outstanding at a time. req_valid outside IDLE is ignored (req_ready=0).
- A response is not consumed in the cycle it first appears unless resp_ready is already high. There is no early or combinational bypass.
- Reset mid-operation:
  - Abandons the access and returns to IDLE.
  - A write already clocked into memory stays.
  - A sub-word store aborted between ACCESS and WRITE leaves the memory word unmodified.

Optional Feature:
- Macro LSU_PERF_CNT_EN.
- When defined, adds outputs load_count[31:0] and store_count[31:0]:
  - Reset to 0.
  - Incremented on the RESP-to-IDLE handshake of each non-error load or store.
  - Wrap at 2^32.
- When undefined, these ports and registers do not exist. All other behaviour is identical.

Decomposition:
- lsu_pkg holds:
  - Size encoding: SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10.
  - State enum: IDLE, CHECK, ACCESS, WRITE, RESP.
  - Lane-width constants.
- Sub-module lsu_lane_align, purely combinational, has two functions:
  - Extract: word, offset, size, signed -> rdata.
  - Merge: word, wdata, offset, size -> merged word.
- The FSM remains in load_store_unit.

Test Plan:
- Word store then load:
  - Stimulus: store 0xDEADBEEF to 1000, then load word from 1000.
  - Required: mem_write pulses once, the load returns 0xDEADBEEF, and resp_valid occurs 3 cycles after each acceptance.
- Sub-word store:
  - Stimulus: memory[1004]=0x11223344; store byte 0xAA to 1006.
  - Required: one mem_read pulse then one mem_write pulse, and memory[1004]=0x11AA3344.
- Signed and unsigned sub-word loads:
  - Stimulus: memory[1008]=0x80F0017F; load byte signed at 1010, unsigned byte at 1010, signed half at 1010, signed half at 1008.
  - Required: 0xFFFFFFF0, 0x000000F0, 0xFFFF80F0, 0x0000017F.
- Error cases:
  - Stimulus: word load at 1002, half store at 1005, word load at 6504.
  - Required: resp_err=1, resp_rdata=0, no memory enable asserted, and response at 2 cycles each.
- Response back-pressure:
  - Stimulus: hold resp_ready=0 for 5 cycles after resp_valid.
  - Required: resp_valid and resp_rdata stay stable, req_ready=0, and the unit returns to IDLE the cycle after resp_ready=1.
- Reset mid-operation:
  - Stimulus: assert rst during WRITE of a half store.
  - Required: all outputs are at reset values the next cycle, and with LSU_PERF_CNT_EN defined, both counters read 0.
